// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer: FSM states,
// command opcodes and the BCD nibble legality check.
package bcd_timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_nibble_ok(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous clear/load, borrow-chained decrement, zero flag.
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       borrow_out,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (dec_en && borrow_in) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

    assign zero       = (q == 4'd0);
    assign borrow_out = borrow_in & zero;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Presettable BCD countdown timer controller with tick prescaler and command
// handshake. Optional macro BCD_TIMER_AUTO_RELOAD_EN reloads the preset on expiry.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 10
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4*DIGITS-1:0]   cmd_data,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [7:0] PSC_LAST = 8'(TICK_DIV - 1);

    state_t                    state;
    logic [4*DIGITS-1:0]       preset;
    logic [7:0]                psc;

    logic [DIGITS-1:0][3:0]    dq;
    logic [DIGITS-1:0]         dzero;
    logic [DIGITS:0]           brw;

    logic acc, legal, cnt_zero, cnt_one;
    logic do_clear, do_load, do_start, do_pause, step, reload;
    logic dig_load;
    logic [4*DIGITS-1:0]       dig_val;

    assign cmd_ready = (state != S_DONE);
    assign acc       = cmd_valid & cmd_ready;

    always_comb begin
        legal = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (!bcd_nibble_ok(cmd_data[4*i +: 4])) legal = 1'b0;
    end

    // cnt_one means the next step lands on zero
    always_comb begin
        cnt_zero = &dzero;
        cnt_one  = (dq[0] == 4'd1);
        for (int i = 1; i < DIGITS; i++)
            if (!dzero[i]) cnt_one = 1'b0;
    end

    assign do_clear = acc & (cmd_op == OP_CLEAR);
    assign do_load  = acc & (cmd_op == OP_LOAD) &
                      (state == S_IDLE || state == S_LOADED || state == S_PAUSE);
    assign do_start = acc & (cmd_op == OP_START) &
                      (state == S_LOADED || state == S_PAUSE);
    assign do_pause = acc & (cmd_op == OP_PAUSE) & (state == S_RUN);

    // Only commands that take effect in RUN (PAUSE, CLEAR) pre-empt a step;
    // ignored LOAD/START leave the countdown undisturbed.
    assign step = (state == S_RUN) & tick & (psc == PSC_LAST) & ~do_clear & ~do_pause;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    assign reload = (state == S_DONE) && (preset != '0);
`else
    assign reload = 1'b0;
`endif

    assign dig_load = (do_load & legal) | reload;
    assign dig_val  = do_load ? cmd_data : preset;

    assign brw[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .clr        (do_clear),
                .load       (dig_load),
                .load_val   (dig_val[4*g +: 4]),
                .dec_en     (step),
                .borrow_in  (brw[g]),
                .q          (dq[g]),
                .borrow_out (brw[g+1]),
                .zero       (dzero[g])
            );
        end
    endgenerate

    assign count = dq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            preset <= '0;
            psc    <= 8'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (do_clear) begin
                state  <= S_IDLE;
                preset <= '0;
                psc    <= 8'd0;
                busy   <= 1'b0;
                err    <= 1'b0;
            end else if (do_load) begin
                if (legal) begin
                    preset <= cmd_data;
                    psc    <= 8'd0;
                    state  <= S_LOADED;
                    busy   <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end else if (do_start) begin
                psc <= 8'd0;
                if (cnt_zero) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                end
            end else if (do_pause) begin
                state <= S_PAUSE;
            end else if (state == S_RUN && tick) begin
                if (psc == PSC_LAST) begin
                    psc <= 8'd0;
                    if (cnt_one) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end else begin
                    psc <= psc + 8'd1;
                end
            end else if (state == S_DONE) begin
                if (reload) begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                    psc   <= 8'd0;
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench: two timers (TICK_DIV 1 and 10) share stimulus; each test
// checks the instance it targets against hand-computed values.
module tb_bcd_timer_ctrl;
    import bcd_timer_pkg::*;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       tick = 1'b0;

    logic       rdy1, busy1, done1, err1;
    logic [7:0] count1;
    logic       rdy10, busy10, done10, err10;
    logic [7:0] count10;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_timer_ctrl #(.DIGITS(2), .TICK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .tick(tick),
        .count(count1), .busy(busy1), .done(done1), .err(err1)
    );

    bcd_timer_ctrl #(.DIGITS(2), .TICK_DIV(10)) u10 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy10),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .tick(tick),
        .count(count10), .busy(busy10), .done(done10), .err(err10)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step_clk();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        #1;
        vectors++; if (count1 !== 8'h00) begin miscompares++; $display("FAIL reset_count got %h want 00", count1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy1); end
        vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done1); end
        vectors++; if (err1 !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err1); end
        vectors++; if (rdy1 !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", rdy1); end
        vectors++; if (rdy10 !== 1'b1 || count10 !== 8'h00) begin miscompares++; $display("FAIL reset_u10 got rdy=%b cnt=%h want 1/00", rdy10, count10); end
        step_clk();
        rst = 1'b1;
        step_clk();
    endtask

    task automatic test_countdown();
        cmd(OP_CLEAR, 8'h00);
        cmd(OP_LOAD, 8'h12);
        vectors++; if (count1 !== 8'h12 || busy1 !== 1'b0) begin miscompares++; $display("FAIL cd_load got cnt=%h busy=%b want 12/0", count1, busy1); end
        tick = 1'b1;
        cmd(OP_START, 8'h00);
        vectors++; if (count1 !== 8'h12 || busy1 !== 1'b1) begin miscompares++; $display("FAIL cd_start got cnt=%h busy=%b want 12/1", count1, busy1); end
        for (int k = 1; k <= 12; k++) begin
            step_clk();
            vectors++; if (count1 !== to_bcd(12 - k)) begin miscompares++; $display("FAIL cd_count step %0d got %h want %h", k, count1, to_bcd(12 - k)); end
            vectors++; if (done1 !== (k == 12)) begin miscompares++; $display("FAIL cd_done step %0d got %b want %b", k, done1, (k == 12)); end
        end
        vectors++; if (rdy1 !== 1'b0 || busy1 !== 1'b0) begin miscompares++; $display("FAIL cd_donestate got rdy=%b busy=%b want 0/0", rdy1, busy1); end
        step_clk();
        tick = 1'b0;
        vectors++; if (done1 !== 1'b0 || rdy1 !== 1'b1) begin miscompares++; $display("FAIL cd_after got done=%b rdy=%b want 0/1", done1, rdy1); end
        vectors++; if (busy1 !== AUTO || count1 !== (AUTO ? 8'h12 : 8'h00)) begin miscompares++; $display("FAIL cd_idle got busy=%b cnt=%h want %b/%h", busy1, count1, AUTO, (AUTO ? 8'h12 : 8'h00)); end
    endtask

    task automatic test_err();
        cmd(OP_CLEAR, 8'h00);
        cmd(OP_LOAD, 8'h1A);
        vectors++; if (err1 !== 1'b1) begin miscompares++; $display("FAIL err_set got %b want 1", err1); end
        vectors++; if (count1 !== 8'h00 || busy1 !== 1'b0) begin miscompares++; $display("FAIL err_nochange got cnt=%h busy=%b want 00/0", count1, busy1); end
        cmd(OP_START, 8'h00);
        vectors++; if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 1'b1) begin miscompares++; $display("FAIL err_idle got busy=%b done=%b err=%b want 0/0/1", busy1, done1, err1); end
        cmd(OP_CLEAR, 8'h00);
        vectors++; if (err1 !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", err1); end
    endtask

    task automatic test_pause();
        cmd(OP_CLEAR, 8'h00);
        cmd(OP_LOAD, 8'h03);
        cmd(OP_START, 8'h00);
        tick = 1'b1;
        for (int k = 0; k < 25; k++) step_clk();
        vectors++; if (count10 !== 8'h01) begin miscompares++; $display("FAIL ps_25 got %h want 01", count10); end
        for (int k = 0; k < 4; k++) step_clk();
        cmd(OP_PAUSE, 8'h00);
        vectors++; if (count10 !== 8'h01 || busy10 !== 1'b1 || done10 !== 1'b0) begin miscompares++; $display("FAIL ps_pause got cnt=%h busy=%b done=%b want 01/1/0", count10, busy10, done10); end
        for (int k = 0; k < 15; k++) step_clk();
        vectors++; if (count10 !== 8'h01 || busy10 !== 1'b1) begin miscompares++; $display("FAIL ps_hold got cnt=%h busy=%b want 01/1", count10, busy10); end
        tick = 1'b0;
        cmd(OP_START, 8'h00);
        vectors++; if (count10 !== 8'h01 || busy10 !== 1'b1) begin miscompares++; $display("FAIL ps_resume got cnt=%h busy=%b want 01/1", count10, busy10); end
        tick = 1'b1;
        for (int k = 0; k < 9; k++) step_clk();
        vectors++; if (count10 !== 8'h01 || done10 !== 1'b0) begin miscompares++; $display("FAIL ps_9 got cnt=%h done=%b want 01/0", count10, done10); end
        step_clk();
        vectors++; if (count10 !== 8'h00 || done10 !== 1'b1) begin miscompares++; $display("FAIL ps_10 got cnt=%h done=%b want 00/1", count10, done10); end
        tick = 1'b0;
        step_clk();
        vectors++; if (done10 !== 1'b0 || busy10 !== AUTO) begin miscompares++; $display("FAIL ps_end got done=%b busy=%b want 0/%b", done10, busy10, AUTO); end
    endtask

    task automatic test_zero_load();
        cmd(OP_CLEAR, 8'h00);
        cmd(OP_LOAD, 8'h00);
        cmd(OP_START, 8'h00);
        vectors++; if (done1 !== 1'b1 || rdy1 !== 1'b0 || count1 !== 8'h00) begin miscompares++; $display("FAIL zl_done got done=%b rdy=%b cnt=%h want 1/0/00", done1, rdy1, count1); end
        step_clk();
        vectors++; if (done1 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0) begin miscompares++; $display("FAIL zl_idle got done=%b rdy=%b busy=%b want 0/1/0", done1, rdy1, busy1); end
    endtask

    task automatic test_async_reset();
        cmd(OP_CLEAR, 8'h00);
        cmd(OP_LOAD, 8'h12);
        tick = 1'b1;
        cmd(OP_START, 8'h00);
        for (int k = 0; k < 5; k++) step_clk();
        vectors++; if (count1 !== 8'h07 || busy1 !== 1'b1) begin miscompares++; $display("FAIL ar_pre got cnt=%h busy=%b want 07/1", count1, busy1); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (count1 !== 8'h00 || done1 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0) begin miscompares++; $display("FAIL ar_async got cnt=%h done=%b rdy=%b busy=%b want 00/0/1/0", count1, done1, rdy1, busy1); end
        step_clk();
        #3 rst = 1'b1;
        step_clk();
        vectors++; if (count1 !== 8'h00 || busy1 !== 1'b0) begin miscompares++; $display("FAIL ar_idle got cnt=%h busy=%b want 00/0", count1, busy1); end
        tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        cmd(OP_CLEAR, 8'h00);
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'h45;
        step_clk();
        vectors++; if (count1 !== 8'h45) begin miscompares++; $display("FAIL bb_first got %h want 45", count1); end
        cmd_data = 8'h99;
        step_clk();
        cmd_valid = 1'b0;
        vectors++; if (count1 !== 8'h99) begin miscompares++; $display("FAIL bb_second got %h want 99", count1); end
        cmd(OP_START, 8'h00);
        cmd(OP_LOAD, 8'h22);
        vectors++; if (count1 !== 8'h99 || busy1 !== 1'b1) begin miscompares++; $display("FAIL bb_runload got cnt=%h busy=%b want 99/1", count1, busy1); end
        tick = 1'b1;
        step_clk();
        vectors++; if (count1 !== 8'h98) begin miscompares++; $display("FAIL bb_step got %h want 98", count1); end
        cmd(OP_CLEAR, 8'h00);
        tick = 1'b0;
        vectors++; if (count1 !== 8'h00 || busy1 !== 1'b0) begin miscompares++; $display("FAIL bb_clear got cnt=%h busy=%b want 00/0", count1, busy1); end
    endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [7:0] ecnt [0:8];
        logic       edone [0:8];
        ecnt  = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
        edone = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        cmd(OP_CLEAR, 8'h00);
        cmd(OP_LOAD, 8'h02);
        tick = 1'b1;
        cmd(OP_START, 8'h00);
        for (int k = 0; k < 9; k++) begin
            step_clk();
            vectors++; if (count1 !== ecnt[k] || done1 !== edone[k]) begin miscompares++; $display("FAIL auto cyc %0d got cnt=%h done=%b want %h/%b", k, count1, done1, ecnt[k], edone[k]); end
        end
        tick = 1'b0;
        cmd(OP_CLEAR, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_err();
        test_pause();
        test_zero_load();
        test_async_reset();
        test_back_to_back();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Synchronous controller that sequences a chain of BCD decade counters as a presettable countdown timer. It accepts LOAD/START/PAUSE/CLEAR commands over a valid/ready handshake and prescales an external tick strobe. It decrements the BCD count and pulses `done` on reaching zero. It sits between the control/register logic and the decade counters, replacing ripple-clocked clearing with a single-clock FSM.

## Interface
- `DIGITS`, default 2: number of BCD decades; count width is 4*DIGITS.
- `TICK_DIV`, default 10: qualified ticks needed per count step; legal range 1..256.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted; transfer when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 00 LOAD, 01 START, 10 PAUSE, 11 CLEAR.
- `cmd_data` in 4*DIGITS: BCD preset; used by LOAD only.
- `tick` in 1: single-cycle time-base strobe.
- `count` out 4*DIGITS: current BCD value, registered.
- `busy` out 1: high in RUN and PAUSE.
- `done` out 1: one-cycle pulse on terminal count.
- `err` out 1: sticky; set on a LOAD with any nibble > 9, cleared only by CLEAR or reset.

## Operation
- States: IDLE, LOADED, RUN, PAUSE, DONE.
- The preset register holds the last legal LOAD value.
- **LOAD** in IDLE/LOADED/PAUSE:
  - All nibbles ≤ 9: preset and count take `cmd_data`, and the state goes to LOADED.
  - Any nibble > 9: `err` is set, and state, count and preset are unchanged.
  - LOAD in RUN is accepted and ignored.
- **START** in LOADED/PAUSE:
  - Count ≠ 0: go to RUN.
  - Count = 0: go to DONE.
  - START in IDLE/RUN is accepted and ignored.
- **PAUSE**: RUN goes to PAUSE with count frozen. Ignored in other states.
- **CLEAR**: valid in every state except DONE. Goes to IDLE and zeros count, preset, prescaler and `err`.
- **Prescaler**:
  - Counts `tick` only in RUN.
  - On the TICK_DIV-th tick it wraps to 0 and issues one step.
  - It is cleared by LOAD, START and CLEAR, and is held in PAUSE.
- **Step**: BCD decrement of `count`.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - The least significant digit is decremented first.
  - A step that produces all zeros moves RUN to DONE.
- **DONE**: lasts exactly one cycle. `done`=1, `count`=0, `cmd_ready`=0, ticks ignored. Then go to IDLE (see Configuration).
- **Simultaneous command and step**: the command wins and the step is dropped. PAUSE freezes the pre-step value; CLEAR zeros.
- `tick` outside RUN is ignored.

## Timing
- Reset values: state IDLE, `count`=0, preset=0, prescaler=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1.
- `cmd_ready` = (state != DONE), decoded combinationally from the state register.
- Command effect: visible on outputs the cycle after the handshake edge.
- Step latency: `count` updates on the edge that samples the TICK_DIV-th `tick`.
- `done` is registered. It is high in the cycle immediately after the edge where `count` becomes 0.
- Full countdown from preset P, with ticks every cycle: TICK_DIV*P cycles from START acceptance to the DONE state.
- Reset asserted mid-RUN: all outputs take their reset values immediately, asynchronously. Operation resumes from IDLE on the first edge after release.

## Configuration
- `BCD_TIMER_AUTO_RELOAD_EN` defined:
  - DONE returns to RUN with `count` reloaded from the preset and the prescaler cleared. `done` still pulses once per expiry.
  - A preset of 0 goes to IDLE instead, with no reload.
- Undefined: DONE always goes to IDLE with `count`=0.

## Structure
- Package `bcd_timer_pkg`: state enum, `cmd_op` encodings, `BCD_MAX`=4'd9, nibble-legality function.
- Sub-module `bcd_digit`: one decade with load, decrement enable, borrow-in/borrow-out and zero flag. It is instantiated DIGITS times in a generate loop.
- FSM, prescaler and handshake logic stay in `bcd_timer_ctrl`.

## Test plan
- Reset, then LOAD 8'h12, START, TICK_DIV=1, tick every cycle: `count` goes 12, 11, 10, 09 … 00. `done`=1 for one cycle exactly 12 cycles after START, then IDLE with `busy`=0.
- LOAD 8'h1A: `err`=1, state stays IDLE, `count`=00. Then CLEAR: `err`=0.
- TICK_DIV=10, LOAD 8'h03, START, 25 ticks, PAUSE on the same cycle as the 30th tick: `count`=01 held, `busy`=1. Ticks during PAUSE cause no change. START resumes and `done` fires after 10 more ticks.
- LOAD 8'h00, START: `done` pulses on the next cycle and `cmd_ready`=0 for that cycle.
- Drop `rst` low mid-RUN at `count`=07: `count`=00, `done`=0 and `cmd_ready`=1 immediately, with no clock edge needed.
- With `BCD_TIMER_AUTO_RELOAD_EN`, LOAD 8'h02, START: `done` pulses every 3 cycles (2 steps plus the DONE cycle), and `count` repeats 02, 01, 00.
